video_mem_scheduler: RTL and testbench

Sequences a single-port video RAM shared between the VGA scan-out path and MiniAlu's pixel-write requests. It also generates 640x480@60 Hz timing from the 50 MHz system clock and drives `oVGA_R/G/B`, `oHorizontal_Sync` and `oVertical_Sync` at the top level. Each 2-clock pixel period is split into a fixed video-read slot and a CPU-write slot. The framebuffer holds one 3-bit colour per 8x8-pixel cell, giving 80x60 = 4800 entries.

---
 rtl/vms_pkg.sv | 33 +++
 rtl/vga_timing_counter.sv | 81 ++++++++
 rtl/video_mem_scheduler.sv | 140 ++++++++++++++
 tb/tb_video_mem_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vms_pkg.sv
// Shared definitions for the video memory scheduler.
// Holds the default 640x480@60 timing constants, their derived totals,
// the framebuffer geometry (one colour per 8x8 cell), the colour type and
// the two-slot pixel phase encoding.
package vms_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int unsigned CELL_SHIFT = 3;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned COLS       = H_ACTIVE >> CELL_SHIFT;  // 80
  localparam int unsigned ROWS       = V_ACTIVE >> CELL_SHIFT;  // 60
  localparam int unsigned CELLS      = COLS * ROWS;             // 4800

  typedef logic [2:0] rgb_t;

  // First half of a pixel period is the video-read slot, second half the CPU slot.
  typedef enum logic {
    PH_VIDEO = 1'b0,
    PH_CPU   = 1'b1
  } phase_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position generator for the video memory scheduler.
// Every pixel lasts two clocks (phase PH_VIDEO then PH_CPU); h/v advance at
// the end of the PH_CPU clock. Sync decodes are combinational and active-low.
// Ports:
//   Clock, Reset      - system clock, synchronous active-high reset
//   h, v              - current pixel column / line
//   phase             - slot within the current pixel period
//   active            - (h, v) lies inside the visible area
//   hSyncN, vSyncN    - unregistered active-low sync decodes of (h, v)
module vga_timing_counter
  import vms_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vms_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vms_pkg::H_FP,
  parameter int unsigned H_SYNC   = vms_pkg::H_SYNC,
  parameter int unsigned H_BP     = vms_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vms_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vms_pkg::V_FP,
  parameter int unsigned V_SYNC   = vms_pkg::V_SYNC,
  parameter int unsigned V_BP     = vms_pkg::V_BP,
  parameter int unsigned H_W      = 10,
  parameter int unsigned V_W      = 10
) (
  input  logic           Clock,
  input  logic           Reset,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output phase_t         phase,
  output logic           active,
  output logic           hSyncN,
  output logic           vSyncN
);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_W-1:0] V_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  phase_t         phaseNext;
  logic [H_W-1:0] hNext;
  logic [V_W-1:0] vNext;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase <= PH_VIDEO;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= phaseNext;
      h     <= hNext;
      v     <= vNext;
    end
  end

  always_comb begin
    phaseNext = phase;
    hNext     = h;
    vNext     = v;
    if (phase == PH_VIDEO) begin
      phaseNext = PH_CPU;
    end else begin
      phaseNext = PH_VIDEO;
      if (h == H_LAST) begin
        hNext = '0;
        vNext = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        hNext = h + 1'b1;
      end
    end
  end

  assign active = (h < H_ACT) && (v < V_ACT);
  assign hSyncN = !((h >= HS_START) && (h < HS_END));
  assign vSyncN = !((v >= VS_START) && (v < VS_END));

endmodule

// File: rtl/video_mem_scheduler.sv
// Single-port video RAM scheduler with 640x480@60 scan-out.
// Each two-clock pixel period gives the scan-out path a fixed read slot
// (phase PH_VIDEO while visible) and hands every other clock to MiniAlu's
// write port via a valid/ready handshake. Out-of-range write addresses
// complete the handshake but never assert the RAM write enable.
// Colour and sync pins are registered together at the end of each pixel.
// Optional build macro VMS_BLANK_WRITE_ONLY_EN: grant writes only while the
// raster is outside the visible area (tear-free updates).
// Ports:
//   Clock, Reset                   - 50 MHz clock, synchronous active-high reset
//   iWrValid/oWrReady              - CPU write handshake
//   iWrAddr, iWrData               - cell address (row*80+col) and RGB colour
//   oMemAddr/oMemWe/oMemWData      - RAM port
//   iMemRData                      - RAM read data, one clock after address
//   oVGA_R/G/B                     - pixel colour
//   oHorizontal_Sync/oVertical_Sync- active-low syncs
//   oFrameStart                    - one-clock pulse with pixel (0,0)
module video_mem_scheduler
  import vms_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = vms_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vms_pkg::H_FP,
  parameter int unsigned H_SYNC     = vms_pkg::H_SYNC,
  parameter int unsigned H_BP       = vms_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vms_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vms_pkg::V_FP,
  parameter int unsigned V_SYNC     = vms_pkg::V_SYNC,
  parameter int unsigned V_BP       = vms_pkg::V_BP,
  parameter int unsigned CELL_SHIFT = vms_pkg::CELL_SHIFT,
  parameter int unsigned ADDR_W     = vms_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iWrValid,
  output logic              oWrReady,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [2:0]        iWrData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemWe,
  output logic [2:0]        oMemWData,
  input  logic [2:0]        iMemRData,
  output logic              oVGA_R,
  output logic              oVGA_G,
  output logic              oVGA_B,
  output logic              oHorizontal_Sync,
  output logic              oVertical_Sync,
  output logic              oFrameStart
);

  localparam int unsigned H_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned V_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned COLS_P  = H_ACTIVE >> CELL_SHIFT;
  localparam int unsigned CELLS_P = COLS_P * (V_ACTIVE >> CELL_SHIFT);

  localparam logic [ADDR_W-1:0] COLS_C  = ADDR_W'(COLS_P);
  localparam logic [ADDR_W-1:0] CELLS_C = ADDR_W'(CELLS_P);

  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  phase_t            phase;
  logic              active;
  logic              hSyncN;
  logic              vSyncN;

  logic              videoSlot;
  logic [ADDR_W-1:0] cellRow;
  logic [ADDR_W-1:0] cellCol;
  logic [ADDR_W-1:0] videoAddr;
  logic              addrInRange;

  rgb_t              rgbReg;
  logic              hSyncReg;
  logic              vSyncReg;
  logic              frameStartReg;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_W      (H_W),
    .V_W      (V_W)
  ) uTiming (
    .Clock  (Clock),
    .Reset  (Reset),
    .h      (h),
    .v      (v),
    .phase  (phase),
    .active (active),
    .hSyncN (hSyncN),
    .vSyncN (vSyncN)
  );

  always_comb begin
    cellRow     = ADDR_W'(v >> CELL_SHIFT);
    cellCol     = ADDR_W'(h >> CELL_SHIFT);
    videoAddr   = cellRow * COLS_C + cellCol;
    addrInRange = (iWrAddr < CELLS_C);
    videoSlot   = active && (phase == PH_VIDEO);
`ifdef VMS_BLANK_WRITE_ONLY_EN
    oWrReady    = !active;
`else
    oWrReady    = !videoSlot;
`endif
    oMemAddr    = videoSlot ? videoAddr : iWrAddr;
    oMemWData   = iWrData;
    oMemWe      = iWrValid && oWrReady && addrInRange;
  end

  // Read data for the phase-0 address arrives during phase 1; syncs and the
  // frame marker are registered on the same edge so all pins stay aligned.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rgbReg        <= '0;
      hSyncReg      <= 1'b1;
      vSyncReg      <= 1'b1;
      frameStartReg <= 1'b0;
    end else begin
      frameStartReg <= 1'b0;
      if (phase == PH_CPU) begin
        rgbReg        <= active ? rgb_t'(iMemRData) : '0;
        hSyncReg      <= hSyncN;
        vSyncReg      <= vSyncN;
        frameStartReg <= (h == '0) && (v == '0);
      end
    end
  end

  assign oVGA_R           = rgbReg[2];
  assign oVGA_G           = rgbReg[1];
  assign oVGA_B           = rgbReg[0];
  assign oHorizontal_Sync = hSyncReg;
  assign oVertical_Sync   = vSyncReg;
  assign oFrameStart      = frameStartReg;

endmodule

// File: tb/tb_video_mem_scheduler.sv
// Directed bench for video_mem_scheduler.
// dut  : default 640x480 timing with a behavioural RAM (handshake, hsync,
//        write-then-display, sustained writes, out-of-range drop).
// dutS : shrunken raster (24x12 pixel frame, 576 clocks) for vsync and
//        frame-start periodicity, read data tied to 3'b111.
// Clock n = n-th clock after reset release; pixel (h,v) is read in clock
// 1600v+2h+1 and shows on the pins during clocks 1600v+2h+3 and +4.
module tb_video_mem_scheduler;

`ifdef VMS_BLANK_WRITE_ONLY_EN
  localparam bit BLANK_ONLY = 1'b1;
`else
  localparam bit BLANK_ONLY = 1'b0;
`endif

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        wrValid;
  logic        wrReady;
  logic [12:0] wrAddr;
  logic [2:0]  wrData;
  logic [12:0] memAddr;
  logic        memWe;
  logic [2:0]  memWData;
  logic [2:0]  memRData;
  logic        vgaR, vgaG, vgaB, hSync, vSync, frameStart;

  logic        sWrReady;
  logic [12:0] sMemAddr;
  logic        sMemWe;
  logic [2:0]  sMemWData;
  logic        sR, sG, sB, sHs, sVs, sFs;

  logic [2:0]  ram [0:8191] = '{default: '0};

  always @(posedge clk) begin
    if (memWe) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  video_mem_scheduler dut (
    .Clock            (clk),
    .Reset            (reset),
    .iWrValid         (wrValid),
    .oWrReady         (wrReady),
    .iWrAddr          (wrAddr),
    .iWrData          (wrData),
    .oMemAddr         (memAddr),
    .oMemWe           (memWe),
    .oMemWData        (memWData),
    .iMemRData        (memRData),
    .oVGA_R           (vgaR),
    .oVGA_G           (vgaG),
    .oVGA_B           (vgaB),
    .oHorizontal_Sync (hSync),
    .oVertical_Sync   (vSync),
    .oFrameStart      (frameStart)
  );

  video_mem_scheduler #(
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (4),
    .H_BP       (2),
    .V_ACTIVE   (8),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .CELL_SHIFT (3),
    .ADDR_W     (13)
  ) dutS (
    .Clock            (clk),
    .Reset            (reset),
    .iWrValid         (1'b0),
    .oWrReady         (sWrReady),
    .iWrAddr          (13'd0),
    .iWrData          (3'd0),
    .oMemAddr         (sMemAddr),
    .oMemWe           (sMemWe),
    .oMemWData        (sMemWData),
    .iMemRData        (3'b111),
    .oVGA_R           (sR),
    .oVGA_G           (sG),
    .oVGA_B           (sB),
    .oHorizontal_Sync (sHs),
    .oVertical_Sync   (sVs),
    .oFrameStart      (sFs)
  );

  int checks   = 0;
  int failures = 0;
  int clkN     = 0;
  int accActive;
  int accBlank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s clk=%0d observed=%0h expected=%0h", tag, clkN, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clkN++;
  endtask

  task automatic goTo(input int n);
    while (clkN < n) tick();
  endtask

  initial begin
    reset   = 1'b1;
    wrValid = 1'b0;
    wrAddr  = '0;
    wrData  = '0;

    // reset held for three clocks
    tick(); tick(); tick();
    chk("rst_hsync", hSync, 1'b1);
    chk("rst_vsync", vSync, 1'b1);
    chk("rst_rgb", {vgaR, vgaG, vgaB}, 3'b000);
    chk("rst_fs", frameStart, 1'b0);
    chk("rst_s_hsync", sHs, 1'b1);
    chk("rst_s_vsync", sVs, 1'b1);
    chk("rst_s_rgb", {sR, sG, sB}, 3'b000);
    reset = 1'b0;
    clkN  = 1;

    // clock 1: phase 0 of visible pixel (0,0) belongs to video
    chk("c1_ready", wrReady, 1'b0);
    chk("c1_we", memWe, 1'b0);
    tick();
    chk("c2_ready", wrReady, !BLANK_ONLY);
    tick();
    chk("c3_fs", frameStart, 1'b1);
    chk("c3_s_fs", sFs, 1'b1);
    chk("c3_s_rgb", {sR, sG, sB}, 3'b111);
    tick();
    chk("c4_fs", frameStart, 1'b0);
    chk("c4_s_fs", sFs, 1'b0);

    // write during visible scan: blocked in phase 0, granted in phase 1
    tick();
    wrValid = 1'b1;
    wrAddr  = 13'd0;
    wrData  = 3'b101;
    #1;
    chk("c5_ready", wrReady, 1'b0);
    chk("c5_we", memWe, 1'b0);
    tick();
    chk("c6_ready", wrReady, !BLANK_ONLY);
    chk("c6_we", memWe, !BLANK_ONLY);
    chk("c6_addr", memAddr, 13'd0);
    chk("c6_wdata", memWData, 3'b101);
    tick();
    wrValid = 1'b0;

    // shrunken raster: blank pixel, vsync window, frame period
    goTo(35);  chk("s_blank_rgb", {sR, sG, sB}, 3'b000);
    goTo(434); chk("s_vs_pre", sVs, 1'b1);
    goTo(435); chk("s_vs_fall", sVs, 1'b0);
    goTo(530); chk("s_vs_last", sVs, 1'b0);
    goTo(531); chk("s_vs_rise", sVs, 1'b1);
    goTo(578); chk("s_fs_pre", sFs, 1'b0);
    goTo(579); chk("s_fs_pulse", sFs, 1'b1);
    goTo(580); chk("s_fs_post", sFs, 1'b0);

    // horizontal blanking forces black even though RAM returns cell 0
    goTo(1290); chk("blank_rgb", {vgaR, vgaG, vgaB}, 3'b000);
    goTo(1314); chk("hs_pre", hSync, 1'b1);
    goTo(1315); chk("hs_fall", hSync, 1'b0);

    // back-to-back writes in blanking: cell 1 = green, cell 0 = magenta
    goTo(1401);
    wrValid = 1'b1;
    wrAddr  = 13'd1;
    wrData  = 3'b010;
    #1;
    chk("blank_ready_p0", wrReady, 1'b1);
    chk("blank_we_p0", memWe, 1'b1);
    chk("blank_addr_p0", memAddr, 13'd1);
    tick();
    wrAddr = 13'd0;
    wrData = 3'b101;
    #1;
    chk("blank_we_p1", memWe, 1'b1);
    chk("blank_addr_p1", memAddr, 13'd0);
    tick();
    wrValid = 1'b0;

    goTo(1506); chk("hs_low_end", hSync, 1'b0);
    goTo(1507); chk("hs_rise", hSync, 1'b1);

    // line 1 pixels: h 0..7 cell 0, h 8..15 cell 1, h 16 cell 2 (empty)
    goTo(1603); chk("pix_h0", {vgaR, vgaG, vgaB}, 3'b101);
    goTo(1618); chk("pix_h7", {vgaR, vgaG, vgaB}, 3'b101);
    goTo(1619); chk("pix_h8", {vgaR, vgaG, vgaB}, 3'b010);
    goTo(1634); chk("pix_h15", {vgaR, vgaG, vgaB}, 3'b010);
    goTo(1635); chk("pix_h16", {vgaR, vgaG, vgaB}, 3'b000);
    goTo(1641); chk("vid_addr_h20_v1", memAddr, 13'd2);

    goTo(2914); chk("hs2_pre", hSync, 1'b1);
    goTo(2915); chk("hs2_fall", hSync, 1'b0);

    // out-of-range address: accepted, not written
    goTo(3000);
    wrValid = 1'b1;
    wrAddr  = 13'd4800;
    wrData  = 3'b111;
    #1;
    chk("oor_ready", wrReady, 1'b1);
    chk("oor_we", memWe, 1'b0);
    tick();
    wrValid = 1'b0;
    wrAddr  = 13'd0;
    chk("oor_ram", ram[4800], 3'b000);

    // sustained requests across line 2
    goTo(3201);
    wrValid   = 1'b1;
    wrAddr    = 13'd100;
    wrData    = 3'b000;
    accActive = 0;
    accBlank  = 0;
    while (clkN <= 4800) begin
      if (wrValid && wrReady) begin
        if (clkN <= 4480) accActive++;
        else accBlank++;
      end
      tick();
    end
    wrValid = 1'b0;
    wrAddr  = 13'd0;
    chk("sust_active", accActive, BLANK_ONLY ? 32'd0 : 32'd640);
    chk("sust_blank", accBlank, 32'd320);

    goTo(4803); chk("pix_v3_h0", {vgaR, vgaG, vgaB}, 3'b101);
    goTo(12833); chk("vid_addr_h16_v8", memAddr, 13'd82);

    // mid-frame reset restarts the raster
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clkN  = 1;
    chk("mr_ready", wrReady, 1'b0);
    chk("mr_hsync", hSync, 1'b1);
    chk("mr_rgb", {vgaR, vgaG, vgaB}, 3'b000);
    chk("mr_fs_c1", frameStart, 1'b0);
    goTo(3); chk("mr_fs_c3", frameStart, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
